// File: rtl/pic_inta_sequencer_pkg.sv
// Shared types and widths for the host-side interrupt acknowledge sequencer.
package pic_pkg;

    localparam int VECTOR_W = 8;
    localparam int CNT_W    = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACK1    = 3'd1,
        GAP     = 3'd2,
        ACK2    = 3'd3,
        PRESENT = 3'd4,
        RECOVER = 3'd5
    } state_e;

endpackage

// File: rtl/pic_inta_sequencer_sync.sv
// Two-flop synchronizer with a synchronous active-high reset to RESET_VAL.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage resynchronisation of the asynchronous input.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_r <= RESET_VAL;
            sync_r <= RESET_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/pic_inta_sequencer.sv
// Generates the two-pulse INTA sequence for an 8259 PIC and hands the captured
// vector to the CPU core over a valid/ready handshake.
module pic_inta_sequencer
    import pic_pkg::*;
#(
    parameter int INTA_LOW_CYCLES = 2,
    parameter int INTA_GAP_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                int_in,
    input  logic                cpu_int_enable,
    input  logic [VECTOR_W-1:0] data_bus_in,
    output logic                inta_n,
    output logic [VECTOR_W-1:0] vector_out,
    output logic                vector_valid,
    input  logic                vector_ready,
    output logic                busy,
    output logic [7:0]          ack_count
);

    localparam logic [CNT_W-1:0] LOW_LOAD = CNT_W'(INTA_LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(INTA_GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic                int_sync_s;
    state_e              state_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                inta_n_r;
    logic [VECTOR_W-1:0] vector_r;
    logic                valid_r;
    logic                busy_r;
    logic [7:0]          ack_count_r;

    sync_2ff #(
        .RESET_VAL (1'b0)
    ) u_int_sync (
        .clk   (clk),
        .reset (reset),
        .d     (int_in),
        .q     (int_sync_s)
    );

    // Sequencer FSM; every output is registered from the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= CNT_ZERO;
            inta_n_r    <= 1'b1;
            vector_r    <= {VECTOR_W{1'b0}};
            valid_r     <= 1'b0;
            busy_r      <= 1'b0;
            ack_count_r <= 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (int_sync_s && cpu_int_enable) begin
                        state_r  <= ACK1;
                        cnt_r    <= LOW_LOAD;
                        inta_n_r <= 1'b0;
                        busy_r   <= 1'b1;
                    end else begin
                        inta_n_r <= 1'b1;
                        busy_r   <= 1'b0;
                    end
                end
                ACK1: begin
                    if (cnt_r == CNT_ZERO) begin
                        state_r  <= GAP;
                        cnt_r    <= GAP_LOAD;
                        inta_n_r <= 1'b1;
                    end else begin
                        cnt_r    <= cnt_r - CNT_ONE;
                        inta_n_r <= 1'b0;
                    end
                end
                GAP: begin
                    if (cnt_r == CNT_ZERO) begin
                        state_r  <= ACK2;
                        cnt_r    <= LOW_LOAD;
                        inta_n_r <= 1'b0;
                    end else begin
                        cnt_r    <= cnt_r - CNT_ONE;
                        inta_n_r <= 1'b1;
                    end
                end
                ACK2: begin
                    // The PIC drives the vector throughout the pulse; take it on the last low cycle.
                    if (cnt_r == CNT_ZERO) begin
                        state_r  <= PRESENT;
                        vector_r <= data_bus_in;
                        valid_r  <= 1'b1;
                        inta_n_r <= 1'b1;
                    end else begin
                        cnt_r    <= cnt_r - CNT_ONE;
                        inta_n_r <= 1'b0;
                    end
                end
                PRESENT: begin
                    if (vector_ready) begin
                        state_r     <= RECOVER;
                        cnt_r       <= GAP_LOAD;
                        valid_r     <= 1'b0;
                        ack_count_r <= ack_count_r + 8'd1;
                    end else begin
                        valid_r <= 1'b1;
                    end
                end
                RECOVER: begin
                    if (cnt_r == CNT_ZERO) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    cnt_r    <= CNT_ZERO;
                    inta_n_r <= 1'b1;
                    valid_r  <= 1'b0;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    assign inta_n       = inta_n_r;
    assign vector_out   = vector_r;
    assign vector_valid = valid_r;
    assign busy         = busy_r;
    assign ack_count    = ack_count_r;

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Randomised and directed bench for two sequencer instances (default and minimum timing).
module tb_pic_inta_sequencer;

    localparam int L0 = 2;
    localparam int G0 = 2;
    localparam int L1 = 1;
    localparam int G1 = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       int_in;
    logic       en;
    logic       ready;
    logic [7:0] data;

    logic       inta0, valid0, busy0;
    logic [7:0] vec0, ack0;
    logic       inta1, valid1, busy1;
    logic [7:0] vec1, ack1;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pic_inta_sequencer #(.INTA_LOW_CYCLES(L0), .INTA_GAP_CYCLES(G0)) dut0 (
        .clk(clk), .reset(reset), .int_in(int_in), .cpu_int_enable(en),
        .data_bus_in(data), .inta_n(inta0), .vector_out(vec0),
        .vector_valid(valid0), .vector_ready(ready), .busy(busy0), .ack_count(ack0)
    );

    pic_inta_sequencer #(.INTA_LOW_CYCLES(L1), .INTA_GAP_CYCLES(G1)) dut1 (
        .clk(clk), .reset(reset), .int_in(int_in), .cpu_int_enable(en),
        .data_bus_in(data), .inta_n(inta1), .vector_out(vec1),
        .vector_valid(valid1), .vector_ready(ready), .busy(busy1), .ack_count(ack1)
    );

    // ---------------- behavioural model: timestamps of each sequence ----------------
    int         n = 0;
    bit         s1, s2;
    bit         act[2];
    int         t0[2];
    int         th[2];
    int         acks[2];
    logic [7:0] mvec[2];
    bit         model_on = 1'b0;

    function automatic int lof(input int i);
        return (i == 0) ? L0 : L1;
    endfunction

    function automatic int gof(input int i);
        return (i == 0) ? G0 : G1;
    endfunction

    // Edge at which the vector is captured: ACK1 entry plus both pulses and the gap.
    function automatic int tpof(input int i);
        return t0[i] + 2 * lof(i) + gof(i);
    endfunction

    function automatic logic exp_inta(input int i);
        int d;
        d = n - t0[i];
        if (!act[i]) return 1'b1;
        if ((d >= 0 && d < lof(i)) || (d >= lof(i) + gof(i) && d < 2 * lof(i) + gof(i))) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic exp_valid(input int i);
        return act[i] && (n >= tpof(i)) && (th[i] < 0);
    endfunction

    always @(posedge clk) begin
        n = n + 1;
        if (reset) begin
            s1 = 1'b0;
            s2 = 1'b0;
            for (int i = 0; i < 2; i++) begin
                act[i]  = 1'b0;
                th[i]   = -1;
                acks[i] = 0;
                mvec[i] = 8'h00;
            end
            model_on = 1'b1;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!act[i]) begin
                    if (s2 && en) begin
                        act[i] = 1'b1;
                        t0[i]  = n;
                        th[i]  = -1;
                    end
                end else if (n == tpof(i)) begin
                    mvec[i] = data;
                end else if (th[i] < 0) begin
                    if (n > tpof(i) && ready) begin
                        th[i]   = n;
                        acks[i] = acks[i] + 1;
                    end
                end else if (n == th[i] + gof(i)) begin
                    act[i] = 1'b0;
                end
            end
            s2 = s1;
            s1 = int_in;
        end
    end

    // ---------------- compare process ----------------
    string lit_name;
    int    lit_act, lit_exp;
    int    lit_req  = 0;
    int    lit_done = 0;

    task automatic chk(input string nm, input int a, input int e);
        vectors = vectors + 1;
        if (a !== e) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, a, e, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_on) begin
            chk("inta_n0", int'(inta0), int'(exp_inta(0)));
            chk("busy0",   int'(busy0), int'(act[0]));
            chk("valid0",  int'(valid0), int'(exp_valid(0)));
            chk("vector0", int'(vec0), int'(mvec[0]));
            chk("ack0",    int'(ack0), acks[0] % 256);
            chk("inta_n1", int'(inta1), int'(exp_inta(1)));
            chk("busy1",   int'(busy1), int'(act[1]));
            chk("valid1",  int'(valid1), int'(exp_valid(1)));
            chk("vector1", int'(vec1), int'(mvec[1]));
            chk("ack1",    int'(ack1), acks[1] % 256);
        end
        if (lit_req != lit_done) begin
            lit_done = lit_req;
            chk(lit_name, lit_act, lit_exp);
        end
    end

    // ---------------- stimulus ----------------
    task automatic pin(input string nm, input int a, input int e);
        lit_name = nm;
        lit_act  = a;
        lit_exp  = e;
        lit_req  = lit_req + 1;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        int_in = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int f0, f1, nv0, nlow0, hs, a2_low, lows, busys;
        logic v;
        reset = 1'b1; int_in = 1'b0; en = 1'b0; ready = 1'b0; data = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk); #1;
        pin("reset_inta_n", int'(inta0), 1);
        pin("reset_vector", int'(vec0), 0);
        pin("reset_busy", int'(busy0), 0);

        // Basic sequence; int_in pulses for one sample so only one sequence runs.
        do_reset();
        int_in = 1'b1; en = 1'b1; ready = 1'b1; data = 8'h48;
        f0 = -1; f1 = -1; nv0 = 0; nlow0 = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 1) int_in = 1'b0;
            if (valid0 && f0 < 0) f0 = k;
            if (valid1 && f1 < 0) f1 = k;
            if (valid0) nv0++;
            if (!inta0) nlow0++;
        end
        pin("basic_latency0", f0, 9);
        pin("basic_latency_min", f1, 6);
        pin("basic_valid_cycles", nv0, 1);
        pin("basic_low_cycles", nlow0, 4);
        pin("basic_vector", int'(vec0), 8'h48);
        pin("basic_ack", int'(ack0), 1);

        // Backpressure: the vector is held and no new sequence starts.
        do_reset();
        int_in = 1'b1; en = 1'b1; ready = 1'b0; data = 8'h48;
        v = 1'b0;
        for (int k = 0; k < 40 && !v; k++) begin
            @(posedge clk); #1;
            v = valid0;
        end
        pin("bp_valid_seen", int'(v), 1);
        repeat (10) @(posedge clk);
        #1;
        pin("bp_vector_held", int'(vec0), 8'h48);
        pin("bp_inta_high", int'(inta0), 1);
        pin("bp_ack_zero", int'(ack0), 0);
        ready = 1'b1; int_in = 1'b0;
        @(posedge clk); #1;
        ready = 1'b0;
        pin("bp_ack_once", int'(ack0), 1);
        repeat (10) @(posedge clk);
        #1;
        pin("bp_ack_stays", int'(ack0), 1);

        // Enable gating, then dropping enable and int_in during GAP.
        do_reset();
        en = 1'b0; int_in = 1'b1; ready = 1'b1; data = 8'hA5;
        lows = 0; busys = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (!inta0) lows++;
            if (busy0) busys++;
        end
        pin("gate_low_cycles", lows, 0);
        pin("gate_busy_cycles", busys, 0);
        en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        en = 1'b0; int_in = 1'b0;
        pin("gap_busy", int'(busy0), 1);
        v = 1'b0;
        for (int k = 0; k < 30 && !v; k++) begin
            @(posedge clk); #1;
            v = valid0;
        end
        pin("gap_valid_seen", int'(v), 1);
        pin("gap_vector", int'(vec0), 8'hA5);

        // Reset while the second pulse is low.
        do_reset();
        int_in = 1'b1; en = 1'b1; ready = 1'b1; data = 8'h3C;
        repeat (7) @(posedge clk);
        #1;
        a2_low = int'(inta0);
        reset = 1'b1; int_in = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        pin("ack2_was_low", a2_low, 0);
        pin("rst_inta_n", int'(inta0), 1);
        pin("rst_valid", int'(valid0), 0);
        pin("rst_ack", int'(ack0), 0);

        // Back-to-back sequences until ack_count wraps.
        do_reset();
        int_in = 1'b1; en = 1'b1; ready = 1'b1;
        hs = 0;
        for (int k = 0; k < 3500 && hs < 256; k++) begin
            @(negedge clk);
            data = 8'($urandom);
            if (valid0 && ready) hs++;
        end
        @(posedge clk); #1;
        int_in = 1'b0;
        pin("wrap_handshakes", hs, 256);
        pin("wrap_ack", int'(ack0), 0);

        // Randomised traffic including occasional resets.
        do_reset();
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) int_in = ~int_in;
            en    = ($urandom_range(0, 9) != 0);
            ready = 1'($urandom_range(0, 1));
            data  = 8'($urandom);
            reset = ($urandom_range(0, 199) == 0);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pic_inta_sequencer.md
Name: pic_inta_sequencer

Overview:
- Host-side interrupt acknowledge sequencer that sits directly downstream of the 8259 PIC top.
- Consumes the PIC's INT output and generates the two-pulse INTA sequence the PIC expects.
- Captures the vector byte the PIC drives on the data bus during the second pulse and hands it to the CPU core over a valid/ready handshake.

Parameters:
- INTA_LOW_CYCLES, 2: clock cycles INTA is held low per pulse; legal range 1..15.
- INTA_GAP_CYCLES, 2: minimum high cycles between the two pulses, and after a completed sequence; legal range 1..15.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- int_in  input  1  INT from the PIC; asynchronous to clk.
- cpu_int_enable  input  1  CPU interrupt-enable flag; gates starting a new sequence.
- data_bus_in  input  8  PIC data bus as seen by the host; carries the vector during the second INTA pulse.
- inta_n  output  1  INTA to the PIC, active low, registered.
- vector_out  output  8  captured interrupt vector.
- vector_valid  output  1  vector_out is valid.
- vector_ready  input  1  CPU core accepts the vector.
- busy  output  1  high in any state other than IDLE.
- ack_count  output  8  count of completed handshakes; wraps 255 -> 0.

Behaviour:
- Reset: clears every output. inta_n=1, vector_out=0x00, vector_valid=0, busy=0, ack_count=0.
  - Reset also clears the synchronizer flops and the cycle counter, and sets state to IDLE.
  - Reset mid-sequence takes effect at the next edge: inta_n returns high and any captured vector is discarded.
- Input synchronization: int_in passes through a 2-flop synchronizer to form int_sync, adding 2 cycles of latency.
- State machine: IDLE, ACK1, GAP, ACK2, PRESENT, RECOVER. A down-counter cnt, 4 bits wide, times each phase.
- IDLE:
  - inta_n=1.
  - If int_sync=1 and cpu_int_enable=1: go to ACK1 and load cnt=INTA_LOW_CYCLES-1.
  - Otherwise stay in IDLE.
- ACK1: inta_n=0. Decrement cnt; at cnt=0 go to GAP and load cnt=INTA_GAP_CYCLES-1.
- GAP: inta_n=1. At cnt=0 go to ACK2 and load cnt=INTA_LOW_CYCLES-1.
- ACK2:
  - inta_n=0.
  - On the edge that leaves ACK2 (cnt=0), latch data_bus_in into vector_out and set vector_valid=1; next state is PRESENT.
  - The sample is therefore taken in the last low cycle of the second pulse.
- PRESENT:
  - inta_n=1. Hold vector_out and vector_valid until vector_ready=1.
  - Handshake edge: clear vector_valid, increment ack_count (mod 256), go to RECOVER, load cnt=INTA_GAP_CYCLES-1.
  - If vector_ready is already high in the first PRESENT cycle, the handshake completes in that cycle.
- RECOVER: inta_n=1. At cnt=0 go to IDLE. This guarantees the PIC has time to drop or re-evaluate INT.
- Sequence abort rules:
  - Once ACK1 is entered, the sequence always runs to PRESENT.
  - Deasserting cpu_int_enable or int_in mid-sequence does not abort it, because the PIC has already committed its ISR.
- INT drops before ACK1: no sequence starts.
- inta_n is driven only from the state register, never glitches, and its outputs are registered.
- Timing with the defaults:
  - int_in rises before edge 1; int_sync=1 after edge 2; ACK1 is entered at edge 3.
  - inta_n is low after edges 3–4, high after 5–6, low after 7–8.
  - vector_valid=1 after edge 9.
  - In general, vector_valid rises 3 + 2*INTA_LOW_CYCLES + INTA_GAP_CYCLES edges after int_in is first sampled.
- Back-to-back interrupts: if int_sync is still high on returning to IDLE, the next sequence starts on the following edge.

Decomposition:
- Shared package pic_pkg holds:
  - The state enum typedef: IDLE, ACK1, GAP, ACK2, PRESENT, RECOVER.
  - Constants VECTOR_W=8 and CNT_W=4.
- Sub-module sync_2ff: a two-flop synchronizer with parameter RESET_VAL=0 and synchronous active-high reset, instantiated for int_in.
- Everything else stays in pic_inta_sequencer.

Test Plan:
- Basic sequence with defaults: data_bus_in=0x48 during ACK2, int_in high, enable=1, ready=1 -> inta_n low for 2 cycles, high for 2, low for 2; vector_out=0x48, vector_valid is high for 1 cycle, ack_count=1.
- Backpressure: ready=0 for 10 cycles after valid -> vector_out holds 0x48, inta_n stays 1, no new sequence starts; ready=1 -> one handshake, ack_count increments once.
- Enable gating and abort rules:
  - int_in high with cpu_int_enable=0 for 20 cycles -> inta_n is never low and busy=0.
  - Drop enable during GAP -> the sequence still completes and delivers the vector.
- Reset in ACK2 -> the next edge gives inta_n=1, vector_valid=0, state IDLE; ack_count keeps its reset value of 0.
- Back-to-back interrupts with int_in held high and ready=1 -> sequences repeat with a RECOVER of exactly INTA_GAP_CYCLES between them; run 256 sequences to check ack_count wraps to 0.
- Minimum parameters INTA_LOW_CYCLES=1, INTA_GAP_CYCLES=1 -> single-cycle pulses, and vector_valid rises 6 edges after int_in is first sampled.
